// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill path: FSM encoding,
// AXI burst/size/response codes, line geometry and the cache read status codes.
package icache_refill_ctrl_pkg;

   localparam int LINE_BEATS  = 8;
   localparam int WORD_W      = 32;
   localparam int LINE_W      = LINE_BEATS * WORD_W;
   localparam int BEAT_IDX_W  = $clog2(LINE_BEATS);

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_DONE
   } refill_state_e;

   typedef enum logic [1:0] {
      ICACHE_READ_OK     = 2'd0,
      ICACHE_READ_ERR    = 2'd1,
      ICACHE_READ_CANCEL = 2'd2
   } icache_read_status_e;

   // Line slot written by a beat; wraps naturally at the line boundary.
   function automatic logic [BEAT_IDX_W-1:0] beat_slot(input logic [BEAT_IDX_W-1:0] start,
                                                       input logic [BEAT_IDX_W-1:0] beat);
      return start + beat;
   endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Beat-indexed line assembly buffer with a single word read port; shared by the
// instruction and data cache refill controllers.
module icache_line_buf
   import icache_refill_ctrl_pkg::*;
#(
   parameter int BEATS = LINE_BEATS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(BEATS)-1:0]   widx,
   input  logic [31:0]                wdata,
   input  logic [$clog2(BEATS)-1:0]   rsel,
   output logic [BEATS*32-1:0]        line,
   output logic [31:0]                word
);

   logic [BEATS*32-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else if (we) begin
         line_q[int'(widx)*32 +: 32] <= wdata;
      end
   end

   assign line = line_q;
   assign word = line_q[int'(rsel)*32 +: 32];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill sequencer: one AXI4 read per miss (8-beat line or
// single uncached word). Optional ICACHE_CRITICAL_WORD_FIRST_EN selects WRAP bursts and adds crit_o.
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter int         BEATS  = LINE_BEATS,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                cached_i,
   input  logic [ADDR_W-1:0]   paddr_i,
   input  logic                cancel_i,
   output logic                busy_o,
   output logic                rend_o,
   output logic [BEATS*32-1:0] line_o,
   output logic [31:0]         word_o,
   output logic                err_o,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   output logic                crit_o,
`endif
   output logic                arvalid_o,
   input  logic                arready_i,
   output logic [ADDR_W-1:0]   araddr_o,
   output logic [7:0]          arlen_o,
   output logic [2:0]          arsize_o,
   output logic [1:0]          arburst_o,
   output logic [3:0]          arid_o,
   input  logic                rvalid_i,
   output logic                rready_o,
   input  logic [31:0]         rdata_i,
   input  logic [1:0]          rresp_i,
   input  logic                rlast_i
);

   refill_state_e         state_q;
   logic                  cached_q;
   logic                  cancel_q;
   logic                  err_q;
   logic [BEAT_IDX_W-1:0] beat_q;
   logic [BEAT_IDX_W-1:0] start_q;
   logic [BEAT_IDX_W-1:0] crit_slot_q;
   logic [31:0]           unc_word_q;
   logic [1:0]            arburst_q;

   logic                  beat_fire;
   logic                  buf_we;
   logic [BEAT_IDX_W-1:0] wr_slot;
   logic [31:0]           buf_word;

   assign beat_fire = (state_q == ST_R) && rvalid_i && rready_o;
   assign buf_we    = beat_fire && cached_q;
   assign wr_slot   = beat_slot(start_q, beat_q);

   icache_line_buf #(.BEATS(BEATS)) u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .widx  (wr_slot),
      .wdata (rdata_i),
      .rsel  (crit_slot_q),
      .line  (line_o),
      .word  (buf_word)
   );

   // Termination follows rlast only; the beat counter just steers the write slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cached_q    <= 1'b0;
         cancel_q    <= 1'b0;
         err_q       <= 1'b0;
         beat_q      <= '0;
         start_q     <= '0;
         crit_slot_q <= '0;
         unc_word_q  <= '0;
         arburst_q   <= AXI_BURST_INCR;
         rend_o      <= 1'b0;
         err_o       <= 1'b0;
         arvalid_o   <= 1'b0;
         rready_o    <= 1'b0;
         araddr_o    <= '0;
         arlen_o     <= '0;
      end else begin
         rend_o <= 1'b0;
         err_o  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  cached_q    <= cached_i;
                  cancel_q    <= 1'b0;
                  err_q       <= 1'b0;
                  beat_q      <= '0;
                  crit_slot_q <= paddr_i[BEAT_IDX_W+1:2];
                  arvalid_o   <= 1'b1;
                  arlen_o     <= cached_i ? 8'(BEATS-1) : 8'd0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                  start_q     <= cached_i ? paddr_i[BEAT_IDX_W+1:2] : '0;
                  arburst_q   <= cached_i ? AXI_BURST_WRAP : AXI_BURST_INCR;
                  araddr_o    <= paddr_i & ~ADDR_W'(3);
`else
                  start_q     <= '0;
                  arburst_q   <= AXI_BURST_INCR;
                  araddr_o    <= cached_i ? (paddr_i & ~ADDR_W'(BEATS*4-1))
                                          : (paddr_i & ~ADDR_W'(3));
`endif
                  state_q     <= ST_AR;
               end
            end
            ST_AR: begin
               if (cancel_i) cancel_q <= 1'b1;
               if (arready_i) begin
                  arvalid_o <= 1'b0;
                  rready_o  <= 1'b1;
                  state_q   <= ST_R;
               end
            end
            ST_R: begin
               if (cancel_i) cancel_q <= 1'b1;
               if (beat_fire) begin
                  beat_q <= beat_q + BEAT_IDX_W'(1);
                  if (!cached_q) unc_word_q <= rdata_i;
                  if (rresp_i != AXI_RESP_OKAY) err_q <= 1'b1;
                  if (rlast_i) begin
                     rready_o <= 1'b0;
                     rend_o   <= !(cancel_q || cancel_i);
                     err_o    <= err_q || (rresp_i != AXI_RESP_OKAY);
                     state_q  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               cancel_q <= 1'b0;
               err_q    <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign word_o    = cached_q ? buf_word : unc_word_q;
   assign arsize_o  = AXI_SIZE_4B;
   assign arburst_o = arburst_q;
   assign arid_o    = AXI_ID;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   assign crit_o = buf_we && (beat_q == '0);
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed refills push expected AR and
// line-end responses into queues that negedge monitors pop and compare.
module tb_icache_refill_ctrl;

   logic         clk;
   logic         rst;
   logic         req_i;
   logic         cached_i;
   logic [31:0]  paddr_i;
   logic         cancel_i;
   logic         busy_o;
   logic         rend_o;
   logic [255:0] line_o;
   logic [31:0]  word_o;
   logic         err_o;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   logic         crit_o;
`endif
   logic         arvalid_o;
   logic         arready_i;
   logic [31:0]  araddr_o;
   logic [7:0]   arlen_o;
   logic [2:0]   arsize_o;
   logic [1:0]   arburst_o;
   logic [3:0]   arid_o;
   logic         rvalid_i;
   logic         rready_o;
   logic [31:0]  rdata_i;
   logic [1:0]   rresp_i;
   logic         rlast_i;

   icache_refill_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .cached_i  (cached_i),
      .paddr_i   (paddr_i),
      .cancel_i  (cancel_i),
      .busy_o    (busy_o),
      .rend_o    (rend_o),
      .line_o    (line_o),
      .word_o    (word_o),
      .err_o     (err_o),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      .crit_o    (crit_o),
`endif
      .arvalid_o (arvalid_o),
      .arready_i (arready_i),
      .araddr_o  (araddr_o),
      .arlen_o   (arlen_o),
      .arsize_o  (arsize_o),
      .arburst_o (arburst_o),
      .arid_o    (arid_o),
      .rvalid_i  (rvalid_i),
      .rready_o  (rready_o),
      .rdata_i   (rdata_i),
      .rresp_i   (rresp_i),
      .rlast_i   (rlast_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
   } ar_exp_t;

   typedef struct {
      logic [255:0] line;
      logic [31:0]  word;
      logic         err;
      int           cyc;
   } r_exp_t;

   ar_exp_t      arq[$];
   r_exp_t       rq[$];
   r_exp_t       mon_e;
   logic [255:0] model_line = '0;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // AR channel must match the head expectation every cycle it is valid.
   always @(negedge clk) begin
      if (!rst && arvalid_o) begin
         if (arq.size() == 0) begin
            checkOutput("ar_unexpected", 1, 0);
         end else begin
            checkOutput("araddr", araddr_o, arq[0].addr);
            checkOutput("arlen", arlen_o, arq[0].len);
            checkOutput("arburst", arburst_o, arq[0].burst);
            checkOutput("arsize", arsize_o, 3'b010);
            checkOutput("arid", arid_o, 4'd0);
            if (arready_i) void'(arq.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rend_o) begin
         if (rq.size() == 0) begin
            checkOutput("rend_unexpected", 1, 0);
         end else begin
            mon_e = rq.pop_front();
            checkOutput("line", line_o, mon_e.line);
            checkOutput("word", word_o, mon_e.word);
            checkOutput("err", err_o, mon_e.err);
            if (mon_e.cyc >= 0) checkOutput("rend_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic applyStimulus(input bit cached, input logic [31:0] paddr, input logic [31:0] base,
                                input logic [31:0] exp_araddr, input logic [31:0] exp_word,
                                input int ar_wait, input bit gapped, input int cancel_at,
                                input int err_beat, input int lat);
      int           n;
      int           nb;
      logic [255:0] nl;
      logic [2:0]   slot;
      logic         e_err;
      logic [1:0]   e_burst;
      nb = cached ? 8 : 1;
      n = 0;
      while (busy_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("idle_before_req", busy_o, 0);
      e_burst = 2'b01;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      if (cached) begin
         exp_araddr = paddr & ~32'h3;
         exp_word   = base;
         e_burst    = 2'b10;
      end
`endif
      arq.push_back('{exp_araddr, cached ? 8'd7 : 8'd0, e_burst});
      nl    = model_line;
      e_err = 1'b0;
      for (int k = 0; k < nb; k++) begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
         slot = paddr[4:2] + 3'(k);
`else
         slot = 3'(k);
`endif
         if (cached) nl[int'(slot)*32 +: 32] = base + 32'(k);
         if (k == err_beat) e_err = 1'b1;
      end
      if (cached) model_line = nl;
      if (cancel_at < 0) rq.push_back('{nl, exp_word, e_err, (lat >= 0) ? cyc + lat : -1});

      req_i    = 1'b1;
      cached_i = cached;
      paddr_i  = paddr;
      @(posedge clk); #1;
      req_i = 1'b0;
      checkOutput("busy_after_req", busy_o, 1);

      repeat (ar_wait) begin
         @(posedge clk); #1;
      end
      arready_i = 1'b1;
      n = 0;
      while (!arvalid_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      arready_i = 1'b0;

      for (int k = 0; k < nb; k++) begin
         if (gapped) begin
            rvalid_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         rvalid_i = 1'b1;
         rdata_i  = base + 32'(k);
         rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
         rlast_i  = (k == nb - 1);
         cancel_i = (k == cancel_at);
         if (cancel_at >= 0 && k >= cancel_at) checkOutput("rready_after_cancel", rready_o, 1);
         @(posedge clk); #1;
         cancel_i = 1'b0;
      end
      rvalid_i = 1'b0;
      rlast_i  = 1'b0;
      rresp_i  = 2'b00;
      if (cancel_at >= 0) checkOutput("rend_suppressed", rend_o, 0);
      @(posedge clk); #1;
      if (cancel_at >= 0) checkOutput("busy_after_cancel", busy_o, 0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"}, busy_o, 0);
      checkOutput({tag, "_rend"}, rend_o, 0);
      checkOutput({tag, "_err"}, err_o, 0);
      checkOutput({tag, "_arvalid"}, arvalid_o, 0);
      checkOutput({tag, "_rready"}, rready_o, 0);
      checkOutput({tag, "_line"}, line_o, 0);
      checkOutput({tag, "_word"}, word_o, 0);
      checkOutput({tag, "_araddr"}, araddr_o, 0);
      checkOutput({tag, "_arlen"}, arlen_o, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; req_i = 1'b0; cached_i = 1'b0; paddr_i = '0; cancel_i = 1'b0;
      arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(1, 32'h1FC0_0014, 32'hA0, 32'h1FC0_0000, 32'hA5, 0, 0, -1, -1, 10);
`ifndef ICACHE_CRITICAL_WORD_FIRST_EN
      checkOutput("line_word5_hold", line_o[191:160], 32'hA5);
`endif
      applyStimulus(0, 32'hBFC0_0008, 32'hDEADBEEF, 32'hBFC0_0008, 32'hDEADBEEF, 0, 0, -1, -1, 3);
      applyStimulus(1, 32'h0000_1048, 32'h1000, 32'h0000_1040, 32'h1002, 5, 1, -1, -1, -1);
      applyStimulus(1, 32'h2000_0024, 32'h200, 32'h2000_0020, 32'h201, 0, 0, 3, -1, -1);
      applyStimulus(0, 32'h2000_0033, 32'h5A5A_0001, 32'h2000_0030, 32'h5A5A_0001, 0, 0, -1, -1, 3);
      applyStimulus(1, 32'h3000_001C, 32'h300, 32'h3000_0000, 32'h307, 0, 0, -1, 6, 10);
      applyStimulus(1, 32'h3000_0000, 32'h400, 32'h3000_0000, 32'h400, 0, 0, -1, -1, 10);

      // Reset in the middle of a line burst, on beat 4.
      arq.push_back('{32'h4000_0000, 8'd7,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                      2'b10
`else
                      2'b01
`endif
                     });
      req_i = 1'b1; cached_i = 1'b1; paddr_i = 32'h4000_0000;
      @(posedge clk); #1;
      req_i = 1'b0;
      arready_i = 1'b1;
      @(posedge clk); #1;
      arready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rvalid_i = 1'b1; rdata_i = 32'hC0 + 32'(k); rlast_i = 1'b0;
         @(posedge clk); #1;
      end
      rdata_i = 32'hC4;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rvalid_i = 1'b0;
      model_line = '0;
      checkResetState("midburst_reset");

      applyStimulus(0, 32'h4000_0104, 32'h77, 32'h4000_0104, 32'h77, 0, 0, -1, -1, 3);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("ar_queue_empty", arq.size(), 0);
      checkOutput("r_queue_empty", rq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-refill sequencer for the two-way instruction cache. It accepts one miss or uncached fetch from the cache's compare stage and issues one AXI4 read: an 8-beat INCR line burst, or a single beat when uncached. It assembles the returned beats into a 256-bit line and presents line plus one-cycle end pulse to the cache RAM write port and tag/valid/LRU update logic. Sits between icache stage 2 and the AXI read channel of the bus bridge.

Parameters:
ADDR_W, 32, address width
BEATS, 8, words per line; fixed by the 8-bank data RAM organisation
AXI_ID, 4'd0, constant arid driven for instruction fetches

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  refill request, sampled only in IDLE
cached_i  in  1  1 = line burst, 0 = single-word uncached read
paddr_i  in  32  physical fetch address
cancel_i  in  1  discard result of in-flight refill (branch flush)
busy_o  out  1  controller not in IDLE
rend_o  out  1  one-cycle pulse: line_o / word_o valid
line_o  out  256  assembled line, word i at bits [32i+31:32i]
word_o  out  32  requested word (cached and uncached)
err_o  out  1  with rend_o: any rresp != OKAY
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
araddr_o  out  32  AXI AR address
arlen_o  out  8  7 cached, 0 uncached
arsize_o  out  3  3'b010
arburst_o  out  2  2'b01 INCR
arid_o  out  4  AXI_ID
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
rdata_i  in  32  AXI R data
rresp_i  in  2  AXI R response
rlast_i  in  1  AXI R last

Behaviour:
- States IDLE, AR, R, DONE. Reset (rst=1 at clk edge) forces IDLE. Outputs after reset: busy_o 0, rend_o 0, err_o 0, arvalid_o 0, rready_o 0, line_o 0, word_o 0, araddr_o 0, arlen_o 0.
- IDLE: req_i=1 latches paddr_i, cached_i -> AR next cycle. araddr_o = paddr & ~32'h1F when cached, else paddr unaligned-word (low 2 bits cleared).
- AR: arvalid_o=1, araddr/arlen held stable until arready_i; handshake -> R. arvalid_o never drops without handshake, including under cancel_i.
- R: rready_o=1. Each rvalid_i beat writes rdata_i into word slot beat counter (3-bit, wraps 7->0), counter increments. Uncached: beat stored in word_o. rresp_i != 0 sets sticky error flag. rlast_i beat -> DONE; the counter value is ignored for termination, rlast governs.
- DONE: one cycle; rend_o=1 unless cancel flag set; err_o = error flag. -> IDLE. Earliest next req_i accepted the cycle after DONE.
- word_o in DONE = line slot paddr[4:2] (cached) or the single beat (uncached).
- cancel_i in AR or R sets cancel flag; transaction still completes on AXI (all beats drained), rend_o suppressed in DONE. cancel_i in IDLE or DONE ignored. Flags clear on entering IDLE.
- Latency, zero-wait bus: req_i cycle 0, arvalid cycle 1, first beat cycle 2, rlast cycle 9, rend_o cycle 10 (cached); cycle 3 (uncached).
- req_i while busy_o=1 ignored; requester must hold until busy_o falls.
- line_o holds last value after rend_o until next beat writes it.

Optional Feature:
ICACHE_CRITICAL_WORD_FIRST_EN: when defined, cached bursts use arburst 2'b10 WRAP with araddr_o = paddr word-aligned; beat k stored in slot (paddr[4:2]+k) mod 8, and an extra one-cycle pulse crit_o (additional output, present only with macro) fires on the first beat with rdata_i as the requested word. Without it: INCR from line base, no crit_o port.

Decomposition:
- Shared package/defines file: state encoding, AXI burst/size/resp constants, BEATS, line width (256), ICACHE_READ-style status codes already used by the cache.
- One sub-module natural: icache_line_buf (8x32 beat-indexed write buffer with word select), reused later by dcache refill.

Test Plan:
- Cached miss paddr 0x1FC0_0014, zero-wait bus, beats 0xA0..0xA7 -> araddr 0x1FC0_0000, arlen 7, rend_o at cycle 10, line_o word5 = 0xA5, word_o 0xA5, err_o 0.
- Uncached paddr 0xBFC0_0008, beat 0xDEADBEEF -> arlen 0, araddr 0xBFC0_0008, rend_o cycle 3, word_o 0xDEADBEEF.
- arready_i held low 5 cycles, rvalid_i gapped randomly -> araddr/arlen stable, all 8 beats in order, single rend_o.
- cancel_i pulsed during beat 3 -> rready stays 1 through rlast, no rend_o, busy_o falls, next req accepted normally.
- rresp 2'b10 on beat 6 -> rend_o with err_o 1; next clean refill err_o 0.
- rst asserted mid-R (beat 4) -> IDLE next cycle, all outputs at reset values, rready_o 0.
